// File: rtl/ram_march_bist.sv
// ram_march_bist: march-test BIST controller for a single-port synchronous RAM.
// Runs W0 up, R0W1 up, R1W0 down and R0 down over every address. It stops on
// the first read mismatch and reports the failing address and data.
// The outputs are registered. The one exception is ram_wr, which is gated by
// the live compare so that a failing read-modify-write never commits its write.
module ram_march_bist #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W0,
        S_R0_RD,
        S_R0_W1,
        S_R1_RD,
        S_R1_W0,
        S_RF_RD,
        S_RF_CMP,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] pat;
    logic [DATA_W-1:0] next_pat;
    logic              wr_q;
    logic              next_wr;
    logic              next_rd;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_din;
    logic              next_busy;
    logic              next_done;
    logic              next_pass;
    logic [ADDR_W-1:0] next_fail_addr;
    logic [DATA_W-1:0] next_fail_data;
    logic [DATA_W-1:0] expected;
    logic              compare_state;
    logic              fail_now;

    // Live compare of the read data returned by the previous read cycle
    always_comb begin
        expected      = (state == S_R1_W0) ? ~pat : pat;
        compare_state = (state == S_R0_W1) || (state == S_R1_W0) || (state == S_RF_CMP);
        fail_now      = compare_state && (ram_dout != expected);
    end

    // A write that is already on the ports is withdrawn in the cycle its read fails
    assign ram_wr = wr_q & ~fail_now;

    // Next-state and next-output decode; each state's port values appear while in that state
    always_comb begin
        next_state     = state;
        next_pat       = pat;
        next_wr        = 1'b0;
        next_rd        = 1'b0;
        next_addr      = ram_addr;
        next_din       = ram_din;
        next_busy      = busy;
        next_done      = 1'b0;
        next_pass      = pass;
        next_fail_addr = fail_addr;
        next_fail_data = fail_data;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    next_pat       = pattern;
                    next_pass      = 1'b0;
                    next_fail_addr = ADDR_ZERO;
                    next_fail_data = '0;
                    next_addr      = ADDR_ZERO;
                    next_wr        = 1'b1;
                    next_din       = pattern;
                    next_busy      = 1'b1;
                    next_state     = S_W0;
                end
            end
            S_W0: begin
                if (ram_addr == ADDR_MAX) begin
                    next_addr  = ADDR_ZERO;
                    next_rd    = 1'b1;
                    next_state = S_R0_RD;
                end else begin
                    next_addr = ram_addr + ADDR_ONE;
                    next_wr   = 1'b1;
                    next_din  = pat;
                end
            end
            S_R0_RD: begin
                next_wr    = 1'b1;
                next_din   = ~pat;
                next_state = S_R0_W1;
            end
            S_R0_W1: begin
                if (fail_now) begin
                    next_fail_addr = ram_addr;
                    next_fail_data = ram_dout;
                    next_busy      = 1'b0;
                    next_done      = 1'b1;
                    next_state     = S_DONE;
                end else if (ram_addr == ADDR_MAX) begin
                    next_rd    = 1'b1;
                    next_state = S_R1_RD;
                end else begin
                    next_addr  = ram_addr + ADDR_ONE;
                    next_rd    = 1'b1;
                    next_state = S_R0_RD;
                end
            end
            S_R1_RD: begin
                next_wr    = 1'b1;
                next_din   = pat;
                next_state = S_R1_W0;
            end
            S_R1_W0: begin
                if (fail_now) begin
                    next_fail_addr = ram_addr;
                    next_fail_data = ram_dout;
                    next_busy      = 1'b0;
                    next_done      = 1'b1;
                    next_state     = S_DONE;
                end else if (ram_addr == ADDR_ZERO) begin
                    next_addr  = ADDR_MAX;
                    next_rd    = 1'b1;
                    next_state = S_RF_RD;
                end else begin
                    next_addr  = ram_addr - ADDR_ONE;
                    next_rd    = 1'b1;
                    next_state = S_R1_RD;
                end
            end
            S_RF_RD: begin
                next_state = S_RF_CMP;
            end
            S_RF_CMP: begin
                if (fail_now) begin
                    next_fail_addr = ram_addr;
                    next_fail_data = ram_dout;
                    next_busy      = 1'b0;
                    next_done      = 1'b1;
                    next_state     = S_DONE;
                end else if (ram_addr == ADDR_ZERO) begin
                    next_busy  = 1'b0;
                    next_done  = 1'b1;
                    next_pass  = 1'b1;
                    next_state = S_DONE;
                end else begin
                    next_addr  = ram_addr - ADDR_ONE;
                    next_rd    = 1'b1;
                    next_state = S_RF_RD;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs and the latched background pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat       <= '0;
            wr_q      <= 1'b0;
            ram_rd    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            pat       <= next_pat;
            wr_q      <= next_wr;
            ram_rd    <= next_rd;
            ram_addr  <= next_addr;
            ram_din   <= next_din;
            busy      <= next_busy;
            done      <= next_done;
            pass      <= next_pass;
            fail_addr <= next_fail_addr;
            fail_data <= next_fail_data;
        end
    end

endmodule
